// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: operation codes,
// FSM state encoding, iteration count and counter width.
package div_unit_pkg;

    // EX-stage operation codes that route a request to the divider
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // Number of quotient bits produced, one per cycle
    localparam int DIV_ITER = 32;

    // Iteration counter width
    localparam int CNT_W = 6;

    // Divider FSM states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_e;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU.
// Produces one quotient bit per cycle and returns {remainder, quotient}.
// Signed operands are divided as magnitudes and the signs are fixed up at the end.
// The ready pulse and the result are registered one cycle after the END state.
// Optional feature macro: DIV_EARLY_OUT_EN. When it is defined, a dividend
// whose magnitude is below the divisor's skips the iterations entirely.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    div_state_e            state_q,  state_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [2*WIDTH:0]      acc_q,    acc_d;     // {remainder(W+1), quotient(W)}
    logic [WIDTH-1:0]      divs_q,   divs_d;    // divisor magnitude
    logic                  negq_q,   negq_d;    // quotient needs negation
    logic                  negr_q,   negr_d;    // remainder needs negation
    logic [2*WIDTH-1:0]    result_q, result_d;
    logic                  ready_q,  ready_d;
    logic                  busy_q,   busy_d;

    logic                  a_neg_s;
    logic                  b_neg_s;
    logic [WIDTH-1:0]      a_mag_s;
    logic [WIDTH-1:0]      b_mag_s;
    logic                  early_s;
    logic [2*WIDTH:0]      acc_sh_s;
    logic [WIDTH:0]        diff_s;
    logic [2*WIDTH:0]      step_s;
    logic [WIDTH-1:0]      quo_s;
    logic [WIDTH-1:0]      rem_s;
    logic [2*WIDTH-1:0]    final_s;

    // Operand magnitudes and sign flags as seen at the latch point
    always_comb begin
        a_neg_s = signed_i & opdata1_i[WIDTH-1];
        b_neg_s = signed_i & opdata2_i[WIDTH-1];
        if (a_neg_s) begin
            a_mag_s = {WIDTH{1'b0}} - opdata1_i;
        end else begin
            a_mag_s = opdata1_i;
        end
        if (b_neg_s) begin
            b_mag_s = {WIDTH{1'b0}} - opdata2_i;
        end else begin
            b_mag_s = opdata2_i;
        end
    end

`ifdef DIV_EARLY_OUT_EN
    // Quotient is trivially zero when the dividend magnitude is below the divisor's
    always_comb begin
        early_s = (a_mag_s < b_mag_s);
    end
`else
    // Every nonzero-divisor operation runs the full iteration count
    always_comb begin
        early_s = 1'b0;
    end
`endif

    // One restoring shift-subtract step; borrow in bit WIDTH means "keep the shifted value"
    always_comb begin
        acc_sh_s = {acc_q[2*WIDTH-1:0], 1'b0};
        diff_s   = acc_sh_s[2*WIDTH:WIDTH] - {1'b0, divs_q};
        if (diff_s[WIDTH]) begin
            step_s = acc_sh_s;
        end else begin
            step_s = {diff_s, acc_sh_s[WIDTH-1:1], 1'b1};
        end
    end

    // Sign fix-up: quotient negated on sign mismatch, remainder follows the dividend
    always_comb begin
        quo_s = acc_q[WIDTH-1:0];
        rem_s = acc_q[2*WIDTH-1:WIDTH];
        if (negq_q) begin
            final_s[WIDTH-1:0] = {WIDTH{1'b0}} - quo_s;
        end else begin
            final_s[WIDTH-1:0] = quo_s;
        end
        if (negr_q) begin
            final_s[2*WIDTH-1:WIDTH] = {WIDTH{1'b0}} - rem_s;
        end else begin
            final_s[2*WIDTH-1:WIDTH] = rem_s;
        end
    end

    // Next-state, datapath and output logic for the divider FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        divs_d   = divs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        ready_d  = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                if (start_i && !annul_i) begin
                    divs_d = b_mag_s;
                    negq_d = a_neg_s ^ b_neg_s;
                    negr_d = a_neg_s;
                    cnt_d  = {CNT_W{1'b0}};
                    if (opdata2_i == {WIDTH{1'b0}}) begin
                        state_d = DIV_ZERO;
                        acc_d   = {(2*WIDTH+1){1'b0}};
                    end else if (early_s) begin
                        state_d = DIV_END;
                        acc_d   = {1'b0, a_mag_s, {WIDTH{1'b0}}};
                    end else begin
                        state_d = DIV_ON;
                        acc_d   = {{(WIDTH+1){1'b0}}, a_mag_s};
                    end
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_ZERO: begin
                if (annul_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d = DIV_END;
                    acc_d   = {(2*WIDTH+1){1'b0}};
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    acc_d = step_s;
                    if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                        state_d = DIV_END;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            DIV_END: begin
                state_d = DIV_IDLE;
                if (!annul_i) begin
                    ready_d  = 1'b1;
                    result_d = final_s;
                end else begin
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d = DIV_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        busy_d = (state_d != DIV_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            acc_q    <= {(2*WIDTH+1){1'b0}};
            divs_q   <= {WIDTH{1'b0}};
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= {(2*WIDTH){1'b0}};
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            divs_q   <= divs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = busy_q;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_div_unit;

    localparam int WIDTH = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic               annul_i;
    logic               signed_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;

    int errors = 0;
    int checks = 0;

    // Free-running clock
    always #5 clk = ~clk;

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division on 64-bit integers, {rem, quo}; zero divisor gives 0
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Reference: edges after the accepting edge until ready is observed
    function automatic int ref_lat(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (b == 32'd0) return 2;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        if (sa < 0) sa = -sa;
        if (sb < 0) sb = -sb;
`ifdef DIV_EARLY_OUT_EN
        if (sa < sb) return 1;
`endif
        return 33;
    endfunction

    // Issue one op from a negedge; returns at the negedge where ready is seen
    task automatic run_op(input string tag, input bit s, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        logic [63:0] exp;
        int          lat;
        int          got;
        exp = ref_div(s, a, b);
        lat = ref_lat(s, a, b);
        start_i   = 1'b1;
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
        @(negedge clk);
        start_i   = 1'b0;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = $urandom_range(0, 1);
        check_eq({tag, "_busy"}, 64'(busy_o), 64'd1);
        got = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (poke && k == 5) begin
                start_i   = 1'b1;
                opdata1_i = 32'd50;
                opdata2_i = 32'd5;
            end else begin
                start_i   = 1'b0;
            end
            if (ready_o) begin
                got = k;
                break;
            end
        end
        start_i = 1'b0;
        check_eq({tag, "_lat"}, 64'(got), 64'(lat));
        check_eq({tag, "_res"}, result_o, exp);
    endtask

    int readies;

    initial begin
        rst       = 1'b0;
        start_i   = 1'b0;
        annul_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_result", result_o, 64'd0);
        check_eq("rst_ready", 64'(ready_o), 64'd0);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic unsigned op, cross-checked against a hand-computed constant
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        check_eq("divu_100_7_const", result_o, {32'd2, 32'd14});
        @(negedge clk);
        check_eq("pulse_width", 64'(ready_o), 64'd0);
        check_eq("hold_result", result_o, {32'd2, 32'd14});

        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_eq("div_m7_2_const", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_eq("div_ovf_const", result_o, {32'd0, 32'h8000_0000});
        run_op("divu_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 1'b0);
        run_op("divu_3_10", 1'b0, 32'd3, 32'd10, 1'b0);
        run_op("busy_start", 1'b0, 32'd1000, 32'd3, 1'b1);

        // Start together with annul in IDLE is ignored
        @(negedge clk);
        start_i   = 1'b1;
        annul_i   = 1'b1;
        opdata1_i = 32'd8;
        opdata2_i = 32'd2;
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        check_eq("annul_start_busy", 64'(busy_o), 64'd0);

        // Annul mid-operation: no ready, result unchanged
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        check_eq("annul_busy", 64'(busy_o), 64'd0);
        readies = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) readies++;
        end
        check_eq("annul_no_ready", 64'(readies), 64'd0);
        check_eq("annul_keep", result_o, ref_div(1'b0, 32'd1000, 32'd3));
        run_op("after_annul", 1'b0, 32'd9, 32'd3, 1'b0);
        check_eq("after_annul_const", result_o, {32'd0, 32'd3});

        // Reset in the middle of an operation
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_result", result_o, 64'd0);
        check_eq("midrst_ready", 64'(ready_o), 64'd0);
        check_eq("midrst_busy", 64'(busy_o), 64'd0);
        rst = 1'b1;
        readies = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) readies++;
        end
        check_eq("midrst_no_ready", 64'(readies), 64'd0);

        // Randomized back-to-back operations
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            bit          s;
            int          sel;
            s   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 5);
            a   = $urandom;
            b   = $urandom;
            case (sel)
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       a = $urandom_range(0, 255);
                3:       b = {28'hFFFF_FFF, 4'($urandom_range(0, 15))};
                default: b = b;
            endcase
            run_op("rand", s, a, b, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_div_unit
